// File: rtl/fp32_pkg.sv
// Shared FP32 field layout, constants and pooling FSM states.
package fp32_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [7:0]  EXP_INF   = 8'hff;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        MULT  = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fp32_arith.sv
// Combinational FP32 add and multiply, round-toward-zero,
// denormals flushed to +0, overflow saturating to signed infinity.
module fp32_arith
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic [31:0] prod
);

    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [7:0]  dexp;
    logic [23:0] mx;
    logic [23:0] my;
    logic [50:0] aligned;
    logic [51:0] s;
    logic [51:0] n;
    logic [5:0]  lz;
    int          e_add;

    // 27 extra bits keep the aligned smaller operand exact, so the
    // final truncation sees the true sum.
    always_comb begin
        x = a;
        y = b;
        if (b[EXP_MSB:0] > a[EXP_MSB:0]) begin
            x = b;
            y = a;
        end
        ex = x[EXP_MSB:EXP_LSB];
        ey = y[EXP_MSB:EXP_LSB];
        mx = (ex == 8'd0) ? 24'd0 : {1'b1, x[MANT_MSB:0]};
        my = (ey == 8'd0) ? 24'd0 : {1'b1, y[MANT_MSB:0]};
        dexp = ex - ey;
        if (dexp >= 8'd27) begin
            // Too small to align: only its presence matters for truncation.
            aligned = (my != 24'd0) ? 51'd1 : 51'd0;
        end else begin
            aligned = {my, 27'd0} >> dexp;
        end
        if (x[SIGN_BIT] == y[SIGN_BIT]) begin
            s = {1'b0, mx, 27'd0} + {1'b0, aligned};
        end else begin
            s = {1'b0, mx, 27'd0} - {1'b0, aligned};
        end
        lz = '0;
        for (int i = 0; i < 51; i++) begin
            if (s[i]) lz = 6'(50 - i);
        end
        e_add = int'(ex);
        if (s[51]) begin
            n = s >> 1;
            e_add = e_add + 1;
        end else begin
            n = s << lz;
            e_add = e_add - int'(lz);
        end
        if (s == '0 || e_add <= 0) begin
            sum = FP32_ZERO;
        end else if (e_add >= 255) begin
            sum = {x[SIGN_BIT], EXP_INF, 23'd0};
        end else begin
            sum = {x[SIGN_BIT], 8'(e_add), n[49:27]};
        end
    end

    logic [23:0] pa;
    logic [23:0] pb;
    logic [47:0] p;
    logic [47:0] pn;
    logic        psign;
    int          e_mul;

    always_comb begin
        pa = {1'b1, a[MANT_MSB:0]};
        pb = {1'b1, b[MANT_MSB:0]};
        p = pa * pb;
        psign = a[SIGN_BIT] ^ b[SIGN_BIT];
        e_mul = int'(a[EXP_MSB:EXP_LSB])
              + int'(b[EXP_MSB:EXP_LSB]) - EXP_BIAS;
        if (p[47]) begin
            pn = p;
            e_mul = e_mul + 1;
        end else begin
            pn = p << 1;
        end
        if (a[EXP_MSB:EXP_LSB] == 8'd0 ||
            b[EXP_MSB:EXP_LSB] == 8'd0 || e_mul <= 0) begin
            prod = FP32_ZERO;
        end else if (e_mul >= 255) begin
            prod = {psign, EXP_INF, 23'd0};
        end else begin
            prod = {psign, 8'(e_mul), pn[46:24]};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{n[51:50], n[26:0], pn[47], pn[23:0]};

endmodule

// File: rtl/avg_pool_single.sv
// Global average pool of one N x N FP32 channel: serial sum,
// then one multiply by the precomputed reciprocal 1/(N*N).
module avg_pool_single
    import fp32_pkg::*;
#(
    parameter int          DATAWIDTH     = 32,
    parameter int          MAT_DIMENSION = 13,
    parameter logic [31:0] DIVISOR       = 32'h3bc1e4bc
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] mat_in_y [MAT_DIMENSION][MAT_DIMENSION],
    output logic [DATAWIDTH-1:0] avg_out,
    output logic [DATAWIDTH-1:0] sum_out,
    output logic                 finished
);

    localparam int IW = (MAT_DIMENSION > 1) ? $clog2(MAT_DIMENSION) : 1;
    localparam logic [IW-1:0] LAST = IW'(MAT_DIMENSION - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic [31:0]   acc;
    logic [31:0]   avg;
    logic          fin;
    logic          acc_en;
    logic          mul_en;
    logic          last;
    logic [31:0]   op_b;
    logic [31:0]   add_res;
    logic [31:0]   mul_res;

    assign last = (row == LAST) && (col == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM:   if (last) state_nxt = MULT;
            MULT:    state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        acc_en = 1'b0;
        mul_en = 1'b0;
        unique case (state)
            ACCUM:   acc_en = 1'b1;
            MULT:    mul_en = 1'b1;
            default: ;
        endcase
    end

    // The single arithmetic unit is shared: element in ACCUM, DIVISOR in MULT.
    assign op_b = mul_en ? DIVISOR : mat_in_y[row][col];

    fp32_arith u_arith (
        .a    (acc),
        .b    (op_b),
        .sum  (add_res),
        .prod (mul_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            acc <= FP32_ZERO;
            avg <= FP32_ZERO;
            fin <= 1'b0;
        end else begin
            if (acc_en) begin
                acc <= add_res;
                if (col == LAST) begin
                    col <= '0;
                    row <= (row == LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (mul_en) begin
                avg <= mul_res;
                fin <= 1'b1;
            end
        end
    end

    assign sum_out  = acc;
    assign avg_out  = avg;
    assign finished = fin;

endmodule

// File: tb/tb_avg_pool_single.sv
// Scoreboard bench: runs push expected results, monitors pop on finish.
module tb_avg_pool_single;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] avg;
        int          edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    logic [31:0] m13 [13][13];
    logic [31:0] m2 [2][2];
    logic [31:0] avg13, sum13, avg2, sum2;
    logic        fin13, fin2;

    int   checks = 0;
    int   failures = 0;
    int   cnt13 = 0;
    int   cnt2 = 0;
    int   done13 = 0;
    int   done2 = 0;
    logic pf13 = 1'b0;
    logic pf2 = 1'b0;
    exp_t q13[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    avg_pool_single dut (
        .clk      (clk),
        .rst      (rst),
        .mat_in_y (m13),
        .avg_out  (avg13),
        .sum_out  (sum13),
        .finished (fin13)
    );

    avg_pool_single #(
        .MAT_DIMENSION (2),
        .DIVISOR       (32'h3e800000)
    ) dut2 (
        .clk      (clk),
        .rst      (rst2),
        .mat_in_y (m2),
        .avg_out  (avg2),
        .sum_out  (sum2),
        .finished (fin2)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cnt13 <= rst ? 0 : cnt13 + 1;
        cnt2  <= rst2 ? 0 : cnt2 + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && fin13 && !pf13) begin
            if (q13.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL finish13: got unexpected finish expected none");
            end else begin
                e = q13.pop_front();
                chk("sum13", sum13, e.sum);
                chk("avg13", avg13, e.avg);
                chk("edge13", 32'(cnt13), 32'(e.edge_n));
            end
            done13++;
        end
        pf13 = fin13;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst2 && fin2 && !pf2) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL finish2: got unexpected finish expected none");
            end else begin
                e = q2.pop_front();
                chk("sum2", sum2, e.sum);
                chk("avg2", avg2, e.avg);
                chk("edge2", 32'(cnt2), 32'(e.edge_n));
            end
            done2++;
        end
        pf2 = fin2;
    end

    task automatic fill13(logic [31:0] v);
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 13; c++)
                m13[r][c] = v;
    endtask

    task automatic wait13(int start);
        for (int i = 0; i < 400 && done13 == start; i++)
            @(posedge clk);
        #1;
        if (done13 == start) begin
            checks++;
            failures++;
            $display("FAIL timeout13: got no finish expected finish");
        end
    endtask

    task automatic reset13(string nm);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({nm, "_rst_sum"}, sum13, 32'h0);
        chk({nm, "_rst_avg"}, avg13, 32'h0);
        chk({nm, "_rst_fin"}, {31'd0, fin13}, 32'h0);
    endtask

    task automatic run13(string nm, logic [31:0] es, logic [31:0] ea);
        int start;
        reset13(nm);
        start = done13;
        q13.push_back('{es, ea, 170});
        rst = 1'b0;
        wait13(start);
    endtask

    initial begin
        int start;
        #100000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        fill13(32'h0);
        m2[0][0] = 32'h3f800000;
        m2[0][1] = 32'h40000000;
        m2[1][0] = 32'h40400000;
        m2[1][1] = 32'h40800000;
        repeat (2) @(posedge clk);
        #1;

        fill13(32'h3f800000);
        run13("ones", 32'h43290000, 32'h3f800000);
        // DONE must ignore later input changes.
        fill13(32'h40000000);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_sum", sum13, 32'h43290000);
        chk("hold_avg", avg13, 32'h3f800000);
        chk("hold_fin", {31'd0, fin13}, 32'h1);

        fill13(32'hbf800000);
        run13("negones", 32'hc3290000, 32'hbf800000);

        fill13(32'h0);
        run13("zeros", 32'h0, 32'h0);

        m13[0][0] = 32'h43290000;
        run13("corner", 32'h43290000, 32'h3f800000);

        // Mid-run reset: partial sum discarded, timing restarts.
        fill13(32'h3f800000);
        reset13("midrst");
        start = done13;
        q13.push_back('{32'h43290000, 32'h3f800000, 170});
        rst = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        chk("partial_sum49", sum13, 32'h42440000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_sum", sum13, 32'h0);
        chk("midrst_avg", avg13, 32'h0);
        chk("midrst_fin", {31'd0, fin13}, 32'h0);
        rst = 1'b0;
        wait13(start);

        start = done2;
        q2.push_back('{32'h41200000, 32'h40200000, 5});
        rst2 = 1'b0;
        for (int i = 0; i < 50 && done2 == start; i++)
            @(posedge clk);
        #1;
        if (done2 == start) begin
            checks++;
            failures++;
            $display("FAIL timeout2: got no finish expected finish");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avg_pool_single.md
# avg_pool_single

Single-channel global average-pool block: reduces a square MAT_DIMENSION×MAT_DIMENSION matrix of IEEE-754 single-precision values to one average. It sequentially accumulates every element, then multiplies the sum by a precomputed reciprocal constant. It sits at the tail of the CNN feature pipeline, producing one pooled value per channel, and raises a done flag when the result is valid.

## Interface
- DATAWIDTH, 32, element/result width; FP32 only, other values unsupported.
- MAT_DIMENSION, 13, matrix side N; N×N elements pooled.
- DIVISOR, 32'h3bc1e4bc, FP32 constant 1/(N×N); caller must keep it consistent with MAT_DIMENSION.
- One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset; restarts the operation.
- mat_in_y  in  [N][N] unpacked array of DATAWIDTH  input matrix, row-major [row][col]; must be held stable from reset release until finished.
- avg_out  out  DATAWIDTH  FP32 average (sum × DIVISOR).
- sum_out  out  DATAWIDTH  FP32 running / final sum.
- finished  out  1  high when avg_out and sum_out are final.

## Operation
- Registered state:
  - row/col index, 0..N-1 each;
  - FP32 accumulator (drives sum_out);
  - avg register;
  - finished flag.
- FSM states: ACCUM, MULT, DONE.
  - Reset enters ACCUM with index (0,0), accumulator 0.
- ACCUM, each cycle:
  - accumulator ← fp_add(accumulator, mat_in_y[row][col]);
  - advance col, wrap col to 0 and increment row;
  - after element (N-1,N-1) go to MULT.
- MULT, one cycle:
  - avg register ← fp_mul(accumulator, DIVISOR);
  - finished ← 1;
  - go to DONE.
- DONE holds all outputs until rst; inputs are ignored.
- FP arithmetic rules:
  - normalized operands only; denormal inputs/results flush to +0;
  - rounding is round-toward-zero (truncate);
  - exponent overflow yields ±Inf;
  - NaN handling is not required;
  - add of opposite signs with equal magnitude yields +0.

## Timing
- Reset values: avg_out = 0, sum_out = 0, finished = 0, FSM = ACCUM, index (0,0).
- rst has priority over all other activity. Asserting it mid-operation discards the partial sum and restarts from (0,0) on the first edge after release.
- Edges are counted after the first rising edge with rst low:
  - edges 1..N²: accumulate one element each;
  - edge N²+1: avg_out valid and finished = 1.
  - For N = 13, finished rises on edge 170.
- sum_out changes every ACCUM cycle and is final from edge N².
- No input handshake. The matrix is sampled element-by-element, so a changed input alters only elements not yet consumed.

## Structure
- Shared package fp32_pkg:
  - field constants: SIGN bit 31, EXP [30:23], MANT [22:0], bias 127;
  - FP32 zero constant;
  - FSM state enum.
- One natural sub-module, fp32_arith: combinational FP32 adder and multiplier (ports a, b, sum, prod), instantiated once.
- Top level holds the FSM, index counters and registers.

## Test plan
- All elements 32'h3f800000 (1.0), N = 13, default DIVISOR:
  - sum_out = 32'h43290000, avg_out = 32'h3f800000;
  - finished rises on edge 170, never earlier.
- All elements 32'hbf800000 (-1.0):
  - sum_out = 32'hc3290000, avg_out = 32'hbf800000.
- All zeros:
  - sum_out = 0, avg_out = 0, finished on edge 170.
- Element [0][0] = 32'h43290000 (169.0), rest 0:
  - sum_out = 32'h43290000, avg_out = 32'h3f800000.
- N = 2, DIVISOR = 32'h3e800000 (0.25), inputs 1.0, 2.0, 3.0, 4.0:
  - sum_out = 32'h41200000, avg_out = 32'h40200000;
  - finished on edge 5.
- Reset pulse at edge 50 of an all-ones run:
  - outputs return to 0 and finished = 0 on that edge;
  - after release, finished again rises exactly 170 edges later with 32'h3f800000.
